// File: rtl/trap_ctrl.sv
// trap_ctrl: M-mode trap controller with prioritised level/edge interrupts,
// direct/vectored mtvec, pipeline flush/redirect sequencing and a small CSR file.
module trap_ctrl #(
    parameter int XLEN = 32,
    parameter int NUM_IRQ = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               csr_rw,
    input  logic [1:0]         csr_op,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               illegal_inst,
    input  logic               l_access_fault,
    input  logic               s_access_fault,
    input  logic               ecall_m,
    input  logic               mret,
    input  logic [XLEN-1:0]    epc_cur,
    input  logic [XLEN-1:0]    epc_next,
    input  logic [XLEN-1:0]    inst_in,
    input  logic [XLEN-1:0]    fault_addr,
    output logic               flush,
    output logic               regwrite_cancel,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    output logic               busy
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REDIRECT = 1'b1;
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE = 12'h304;
    localparam logic [11:0] A_MTVEC = 12'h305;
    localparam logic [11:0] A_MEPC = 12'h341;
    localparam logic [11:0] A_MCAUSE = 12'h342;
    localparam logic [11:0] A_MTVAL = 12'h343;
    localparam logic [11:0] A_MIP = 12'h344;

    logic [0:0] state;
    logic st_mie, st_mpie;
    logic [NUM_IRQ-1:0] mie_r, edge_q, irq_q, mip_b, pend, rise, edge_clr;
    logic [XLEN-1:0] mtvec, mepc, mcause, mtval, rpc;
    logic [XLEN-1:0] mstatus_v, mip_v, mie_v, csr_new, base, trap_pc, cause, tval;
    logic [3:0] idx;
    logic act, exc, irq_take, take, do_mret, wr;

    always_comb begin
        rise = irq & ~irq_q & EDGE_MASK;
        mip_b = (edge_q & EDGE_MASK) | (irq & ~EDGE_MASK);
        pend = mip_b & mie_r;
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (pend[i]) idx = 4'(i);
        mstatus_v = '0;
        mstatus_v[12:11] = 2'b11;
        mstatus_v[7] = st_mpie;
        mstatus_v[3] = st_mie;
        mip_v = '0;
        mip_v[16 +: NUM_IRQ] = mip_b;
        mie_v = '0;
        mie_v[16 +: NUM_IRQ] = mie_r;
    end

    always_comb begin
        case (csr_addr)
            A_MSTATUS: csr_rdata = mstatus_v;
            A_MIE:     csr_rdata = mie_v;
            A_MTVEC:   csr_rdata = mtvec;
            A_MEPC:    csr_rdata = mepc;
            A_MCAUSE:  csr_rdata = mcause;
            A_MTVAL:   csr_rdata = mtval;
            A_MIP:     csr_rdata = mip_v;
            default:   csr_rdata = '0;
        endcase
    end

    always_comb begin
        act = (state == IDLE) & ~rst;
        exc = illegal_inst | ecall_m | l_access_fault | s_access_fault;
        irq_take = st_mie & |pend;
        take = act & (exc | irq_take);
        do_mret = act & ~exc & ~irq_take & mret;
        wr = act & ~take & ~do_mret & csr_rw & |csr_op;
        csr_new = csr_op == 2'b01 ? csr_wdata :
                  csr_op == 2'b10 ? csr_rdata | csr_wdata : csr_rdata & ~csr_wdata;
        // An edge arriving in the clearing cycle is OR-ed back in after the clear
        edge_clr = (wr && csr_addr == A_MIP) ? ~csr_new[16 +: NUM_IRQ] & EDGE_MASK : '0;
        cause = illegal_inst   ? XLEN'(2) :
                ecall_m        ? XLEN'(11) :
                l_access_fault ? XLEN'(5) :
                s_access_fault ? XLEN'(7) : {1'b1, {(XLEN-6){1'b0}}, 1'b1, idx};
        tval = illegal_inst ? inst_in : (ecall_m | ~exc) ? '0 : fault_addr;
        base = {mtvec[XLEN-1:2], 2'b00};
        trap_pc = (~exc && mtvec[1:0] == 2'b01) ? base + {{(XLEN-7){1'b0}}, 1'b1, idx, 2'b00} : base;
        flush = take | do_mret | (state == REDIRECT);
        regwrite_cancel = take;
        redirect_valid = state == REDIRECT;
        busy = state != IDLE;
        redirect_pc = rpc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            st_mie <= 1'b0;
            st_mpie <= 1'b0;
            mie_r <= '0;
            edge_q <= '0;
            irq_q <= '0;
            mtvec <= RESET_MTVEC;
            mepc <= '0;
            mcause <= '0;
            mtval <= '0;
            rpc <= '0;
        end else begin
            irq_q <= irq;
            edge_q <= (edge_q & ~edge_clr) | rise;
            state <= (take | do_mret) ? REDIRECT : IDLE;
            if (take) begin
                mepc <= (exc ? epc_cur : epc_next) & ~XLEN'(3);
                mcause <= cause;
                mtval <= tval;
                st_mpie <= st_mie;
                st_mie <= 1'b0;
                rpc <= trap_pc;
            end else if (do_mret) begin
                st_mie <= st_mpie;
                st_mpie <= 1'b1;
                rpc <= mepc;
            end else if (wr) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        st_mie <= csr_new[3];
                        st_mpie <= csr_new[7];
                    end
                    A_MIE:    mie_r <= csr_new[16 +: NUM_IRQ];
                    A_MTVEC:  mtvec <= csr_new;
                    A_MEPC:   mepc <= csr_new & ~XLEN'(3);
                    A_MCAUSE: mcause <= csr_new;
                    A_MTVAL:  mtval <= csr_new;
                    default:  ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed-vector bench for trap_ctrl (irq[3] configured as edge line).
module tb_trap_ctrl;
    logic clk = 0, rst = 1;
    logic csr_rw = 0;
    logic [1:0] csr_op = 0;
    logic [11:0] csr_addr = 0;
    logic [31:0] csr_wdata = 0, csr_rdata;
    logic [3:0] irq = 0;
    logic illegal_inst = 0, l_access_fault = 0, s_access_fault = 0, ecall_m = 0, mret = 0;
    logic [31:0] epc_cur = 0, epc_next = 0, inst_in = 0, fault_addr = 0;
    logic flush, regwrite_cancel, redirect_valid, busy;
    logic [31:0] redirect_pc;
    int vec = 0, miscmp = 0;
    logic [31:0] d;

    trap_ctrl #(.XLEN(32), .NUM_IRQ(4), .EDGE_MASK(4'b1000), .RESET_MTVEC(32'h0)) dut (
        .clk(clk), .rst(rst), .csr_rw(csr_rw), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .irq(irq), .illegal_inst(illegal_inst),
        .l_access_fault(l_access_fault), .s_access_fault(s_access_fault), .ecall_m(ecall_m),
        .mret(mret), .epc_cur(epc_cur), .epc_next(epc_next), .inst_in(inst_in),
        .fault_addr(fault_addr), .flush(flush), .regwrite_cancel(regwrite_cancel),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] v);
        @(negedge clk);
        csr_rw = 1; csr_op = op; csr_addr = a; csr_wdata = v;
        @(negedge clk);
        csr_rw = 0; csr_op = 0; csr_wdata = 0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] v);
        @(negedge clk);
        csr_addr = a;
        #1 v = csr_rdata;
    endtask

    task automatic test_reset;
        @(negedge clk); @(negedge clk);
        rst = 0;
        #1;
        vec++; if ({flush, regwrite_cancel, redirect_valid, busy} !== 4'b0) begin miscmp++; $display("FAIL rst_outs got %b want 0000", {flush, regwrite_cancel, redirect_valid, busy}); end
        vec++; if (redirect_pc !== 32'h0) begin miscmp++; $display("FAIL rst_pc got %h want 0", redirect_pc); end
        rd(12'h300, d); vec++; if (d !== 32'h1800) begin miscmp++; $display("FAIL rst_mstatus got %h want 1800", d); end
        rd(12'h305, d); vec++; if (d !== 32'h0) begin miscmp++; $display("FAIL rst_mtvec got %h want 0", d); end
        rd(12'h344, d); vec++; if (d !== 32'h0) begin miscmp++; $display("FAIL rst_mip got %h want 0", d); end
    endtask

    task automatic test_csr_masks;
        csr(2'b01, 12'h300, 32'hFFFFFFFF);
        rd(12'h300, d); vec++; if (d !== 32'h1888) begin miscmp++; $display("FAIL mask_mstatus got %h want 1888", d); end
        csr(2'b01, 12'h304, 32'hFFFFFFFF);
        rd(12'h304, d); vec++; if (d !== 32'h000F0000) begin miscmp++; $display("FAIL mask_mie got %h want f0000", d); end
        csr(2'b01, 12'h341, 32'h303);
        rd(12'h341, d); vec++; if (d !== 32'h300) begin miscmp++; $display("FAIL mask_mepc got %h want 300", d); end
        csr(2'b01, 12'h343, 32'hF0);
        csr(2'b10, 12'h343, 32'h0F);
        rd(12'h343, d); vec++; if (d !== 32'hFF) begin miscmp++; $display("FAIL set_mtval got %h want ff", d); end
        csr(2'b11, 12'h343, 32'hF0);
        rd(12'h343, d); vec++; if (d !== 32'h0F) begin miscmp++; $display("FAIL clr_mtval got %h want 0f", d); end
        csr(2'b01, 12'h340, 32'hFFFFFFFF);
        rd(12'h340, d); vec++; if (d !== 32'h0) begin miscmp++; $display("FAIL unimpl got %h want 0", d); end
        csr(2'b01, 12'h300, 32'h0);
        csr(2'b01, 12'h304, 32'h0);
    endtask

    task automatic test_illegal;
        csr(2'b01, 12'h305, 32'h800);
        csr(2'b10, 12'h300, 32'h8);
        @(negedge clk);
        illegal_inst = 1; epc_cur = 32'h100; inst_in = 32'hFFFFFFFF;
        #1;
        vec++; if ({flush, regwrite_cancel, redirect_valid} !== 3'b110) begin miscmp++; $display("FAIL ill_T got %b want 110", {flush, regwrite_cancel, redirect_valid}); end
        @(negedge clk);
        illegal_inst = 0;
        #1;
        vec++; if ({flush, regwrite_cancel, redirect_valid, busy} !== 4'b1011) begin miscmp++; $display("FAIL ill_T1 got %b want 1011", {flush, regwrite_cancel, redirect_valid, busy}); end
        vec++; if (redirect_pc !== 32'h800) begin miscmp++; $display("FAIL ill_pc got %h want 800", redirect_pc); end
        @(negedge clk);
        #1;
        vec++; if ({flush, redirect_valid, busy} !== 3'b000) begin miscmp++; $display("FAIL ill_T2 got %b want 000", {flush, redirect_valid, busy}); end
        rd(12'h341, d); vec++; if (d !== 32'h100) begin miscmp++; $display("FAIL ill_mepc got %h want 100", d); end
        rd(12'h342, d); vec++; if (d !== 32'h2) begin miscmp++; $display("FAIL ill_mcause got %h want 2", d); end
        rd(12'h343, d); vec++; if (d !== 32'hFFFFFFFF) begin miscmp++; $display("FAIL ill_mtval got %h want ffffffff", d); end
        rd(12'h300, d); vec++; if (d !== 32'h1880) begin miscmp++; $display("FAIL ill_mstatus got %h want 1880", d); end
    endtask

    task automatic test_irq_vectored;
        csr(2'b01, 12'h305, 32'h801);
        csr(2'b01, 12'h304, 32'h20000);
        csr(2'b10, 12'h300, 32'h8);
        @(negedge clk);
        irq = 4'b0010; epc_next = 32'h204;
        #1;
        vec++; if ({flush, regwrite_cancel} !== 2'b11) begin miscmp++; $display("FAIL irq_T got %b want 11", {flush, regwrite_cancel}); end
        @(negedge clk);
        irq = 0;
        #1;
        vec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h844) begin miscmp++; $display("FAIL irq_pc got %b/%h want 1/844", redirect_valid, redirect_pc); end
        rd(12'h342, d); vec++; if (d !== 32'h80000011) begin miscmp++; $display("FAIL irq_mcause got %h want 80000011", d); end
        rd(12'h341, d); vec++; if (d !== 32'h204) begin miscmp++; $display("FAIL irq_mepc got %h want 204", d); end
    endtask

    task automatic test_priority;
        csr(2'b01, 12'h304, 32'h50000);
        csr(2'b10, 12'h300, 32'h8);
        @(negedge clk);
        irq = 4'b0101;
        #1;
        vec++; if (regwrite_cancel !== 1'b1) begin miscmp++; $display("FAIL pri_T got %b want 1", regwrite_cancel); end
        @(negedge clk);
        irq = 0;
        #1;
        vec++; if (redirect_pc !== 32'h840) begin miscmp++; $display("FAIL pri_pc got %h want 840", redirect_pc); end
        rd(12'h342, d); vec++; if (d !== 32'h80000010) begin miscmp++; $display("FAIL pri_mcause got %h want 80000010", d); end
        csr(2'b10, 12'h300, 32'h8);
        @(negedge clk);
        irq = 4'b0101; ecall_m = 1; epc_cur = 32'h400;
        #1;
        vec++; if (regwrite_cancel !== 1'b1) begin miscmp++; $display("FAIL ecl_T got %b want 1", regwrite_cancel); end
        @(negedge clk);
        irq = 0; ecall_m = 0;
        #1;
        vec++; if (redirect_pc !== 32'h800) begin miscmp++; $display("FAIL ecl_pc got %h want 800", redirect_pc); end
        rd(12'h342, d); vec++; if (d !== 32'hB) begin miscmp++; $display("FAIL ecl_mcause got %h want b", d); end
        rd(12'h341, d); vec++; if (d !== 32'h400) begin miscmp++; $display("FAIL ecl_mepc got %h want 400", d); end
        rd(12'h343, d); vec++; if (d !== 32'h0) begin miscmp++; $display("FAIL ecl_mtval got %h want 0", d); end
    endtask

    task automatic test_edge;
        @(negedge clk); irq = 4'b1000;
        @(negedge clk); irq = 4'b0000;
        rd(12'h344, d); vec++; if (d !== 32'h80000) begin miscmp++; $display("FAIL edge_latch got %h want 80000", d); end
        rd(12'h344, d); vec++; if (d !== 32'h80000) begin miscmp++; $display("FAIL edge_hold got %h want 80000", d); end
        csr(2'b11, 12'h344, 32'h80000);
        rd(12'h344, d); vec++; if (d !== 32'h0) begin miscmp++; $display("FAIL edge_clr got %h want 0", d); end
        @(negedge clk); irq = 4'b1000;
        @(negedge clk); irq = 4'b0000;
        @(negedge clk);
        csr_rw = 1; csr_op = 2'b11; csr_addr = 12'h344; csr_wdata = 32'h80000; irq = 4'b1000;
        @(negedge clk);
        csr_rw = 0; csr_op = 0; csr_wdata = 0; irq = 4'b0000;
        rd(12'h344, d); vec++; if (d !== 32'h80000) begin miscmp++; $display("FAIL edge_race got %h want 80000", d); end
        csr(2'b01, 12'h344, 32'h0);
        rd(12'h344, d); vec++; if (d !== 32'h0) begin miscmp++; $display("FAIL edge_w0 got %h want 0", d); end
        @(negedge clk); irq = 4'b0010;
        rd(12'h344, d); vec++; if (d !== 32'h20000) begin miscmp++; $display("FAIL level_mip got %h want 20000", d); end
        @(negedge clk); irq = 4'b0000;
        rd(12'h344, d); vec++; if (d !== 32'h0) begin miscmp++; $display("FAIL level_drop got %h want 0", d); end
    endtask

    task automatic test_mret;
        csr(2'b01, 12'h341, 32'h300);
        csr(2'b01, 12'h300, 32'h80);
        @(negedge clk);
        mret = 1;
        #1;
        vec++; if ({flush, regwrite_cancel} !== 2'b10) begin miscmp++; $display("FAIL mret_T got %b want 10", {flush, regwrite_cancel}); end
        @(negedge clk);
        mret = 0;
        #1;
        vec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin miscmp++; $display("FAIL mret_pc got %b/%h want 1/300", redirect_valid, redirect_pc); end
        rd(12'h300, d); vec++; if (d !== 32'h1888) begin miscmp++; $display("FAIL mret_mstatus got %h want 1888", d); end
    endtask

    task automatic test_drop_write;
        csr(2'b01, 12'h300, 32'h0);
        @(negedge clk);
        csr_rw = 1; csr_op = 2'b10; csr_addr = 12'h300; csr_wdata = 32'h8; ecall_m = 1; epc_cur = 32'h500;
        #1;
        vec++; if (regwrite_cancel !== 1'b1) begin miscmp++; $display("FAIL drop_T got %b want 1", regwrite_cancel); end
        @(negedge clk);
        csr_rw = 0; csr_op = 0; csr_wdata = 0; ecall_m = 0;
        #1;
        vec++; if (redirect_pc !== 32'h800) begin miscmp++; $display("FAIL drop_pc got %h want 800", redirect_pc); end
        rd(12'h300, d); vec++; if (d !== 32'h1800) begin miscmp++; $display("FAIL drop_mstatus got %h want 1800", d); end
        rd(12'h341, d); vec++; if (d !== 32'h500) begin miscmp++; $display("FAIL drop_mepc got %h want 500", d); end
    endtask

    task automatic test_rst_redirect;
        @(negedge clk);
        ecall_m = 1; epc_cur = 32'h600;
        @(negedge clk);
        ecall_m = 0;
        #1;
        vec++; if (redirect_valid !== 1'b1) begin miscmp++; $display("FAIL rr_pre got %b want 1", redirect_valid); end
        rst = 1;
        #1;
        vec++; if ({flush, redirect_valid, busy} !== 3'b000) begin miscmp++; $display("FAIL rr_async got %b want 000", {flush, redirect_valid, busy}); end
        rd(12'h305, d); vec++; if (d !== 32'h0) begin miscmp++; $display("FAIL rr_mtvec got %h want 0", d); end
        rd(12'h342, d); vec++; if (d !== 32'h0) begin miscmp++; $display("FAIL rr_mcause got %h want 0", d); end
        rd(12'h300, d); vec++; if (d !== 32'h1800) begin miscmp++; $display("FAIL rr_mstatus got %h want 1800", d); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_back_to_back;
        csr(2'b01, 12'h305, 32'h900);
        @(negedge clk);
        illegal_inst = 1; epc_cur = 32'h700; inst_in = 32'h13;
        @(negedge clk);
        illegal_inst = 0;
        #1;
        vec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h900) begin miscmp++; $display("FAIL b2b_r1 got %b/%h want 1/900", redirect_valid, redirect_pc); end
        @(negedge clk);
        ecall_m = 1; epc_cur = 32'h704;
        #1;
        vec++; if ({regwrite_cancel, busy} !== 2'b10) begin miscmp++; $display("FAIL b2b_T2 got %b want 10", {regwrite_cancel, busy}); end
        @(negedge clk);
        ecall_m = 0;
        #1;
        vec++; if (redirect_valid !== 1'b1) begin miscmp++; $display("FAIL b2b_r2 got %b want 1", redirect_valid); end
        rd(12'h342, d); vec++; if (d !== 32'hB) begin miscmp++; $display("FAIL b2b_mcause got %h want b", d); end
        rd(12'h341, d); vec++; if (d !== 32'h704) begin miscmp++; $display("FAIL b2b_mepc got %h want 704", d); end
    endtask

    initial begin
        test_reset;
        test_csr_masks;
        test_illegal;
        test_irq_vectored;
        test_priority;
        test_edge;
        test_mret;
        test_drop_write;
        test_rst_redirect;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule
